// File: rtl/bmp_stream_proc.sv
// BMP copy/process engine: streams a BMP file from ROM to RAM, validating the header
// and applying a runtime-selected pixel operation to bytes at or above the pixel offset.
module bmp_stream_proc #(
  parameter int ADDR_WIDTH = 20,
  parameter int MAX_SIZE   = 786486,
  parameter int PIX_BYTES  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            mode,
  input  logic [7:0]            thr,
  input  logic [7:0]            ROM_Q,
  output logic                  ROM_valid,
  output logic [ADDR_WIDTH-1:0] ROM_addr,
  output logic                  RAM_valid,
  output logic [7:0]            RAM_D,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0] MAX32  = 32'(MAX_SIZE);
  localparam logic [1:0]  K_LAST = 2'(PIX_BYTES - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} state_t;

  typedef struct packed {
    logic                  v;
    logic [ADDR_WIDTH-1:0] a;
    logic [7:0]            d;
    logic                  pix;
    logic                  whole;
    logic [1:0]            k;
  } stage_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [31:0]           size_reg;
  logic [31:0]           off_reg;
  logic                  size_known;
  logic [1:0]            mode_reg;
  logic [7:0]            thr_reg;
  logic                  rx_v;
  logic [ADDR_WIDTH-1:0] rx_a;
  logic [1:0]            pix_k;
  stage_t                s1;
  stage_t                s2;
  logic [7:0]            gray_reg;

  logic [31:0] limit;
  logic [31:0] rx_ext;
  logic [31:0] rd_ext;
  logic [31:0] size_full;
  logic [31:0] off_full;
  logic        fault;
  stage_t      rx_stage;
  logic [9:0]  gray_sum;
  logic [7:0]  gray_now;
  logic [7:0]  shade;
  logic [7:0]  out_d;

  // rx stage is the byte currently on ROM_Q; when s2 holds a pixel's B byte,
  // s1 holds G and ROM_Q holds R, so gray is formed just in time for B's write.
  always_comb begin
    limit     = size_known ? size_reg : MAX32;
    rx_ext    = 32'(rx_a);
    rd_ext    = 32'(rd_addr);
    size_full = {ROM_Q, size_reg[23:0]};
    off_full  = {ROM_Q, off_reg[23:0]};
    fault     = 1'b0;
    if (rx_v) begin
      case (rx_ext)
        32'd0:   fault = (ROM_Q != 8'h42);
        32'd1:   fault = (ROM_Q != 8'h4D);
        32'd5:   fault = (size_full > MAX32) || (size_full < 32'd54);
        32'd13:  fault = (off_full < 32'd14) || (off_full >= size_reg);
        default: fault = 1'b0;
      endcase
    end

    rx_stage.v     = rx_v;
    rx_stage.a     = rx_a;
    rx_stage.d     = ROM_Q;
    rx_stage.pix   = rx_v && (rx_ext >= 32'd14) && (rx_ext >= off_reg);
    rx_stage.whole = (rx_ext - 32'(pix_k) + 32'(PIX_BYTES)) <= size_reg;
    rx_stage.k     = pix_k;

    gray_sum = 10'(s2.d) + {1'b0, s1.d, 1'b0} + 10'(ROM_Q);
    gray_now = 8'(gray_sum >> 2);
    shade    = (s2.k == 2'd0) ? gray_now : gray_reg;

    out_d = s2.d;
    if (s2.pix && s2.whole && !(PIX_BYTES == 4 && s2.k == 2'd3)) begin
      case (mode_reg)
        2'd1:    out_d = ~s2.d;
        2'd2:    out_d = shade;
        2'd3:    out_d = (shade >= thr_reg) ? 8'hFF : 8'h00;
        default: out_d = s2.d;
      endcase
    end
  end

  // Read issue, header capture, 3-stage write delay line and control FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ROM_valid  <= 1'b0;
      ROM_addr   <= '0;
      RAM_valid  <= 1'b0;
      RAM_D      <= 8'h00;
      RAM_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rd_addr    <= '0;
      size_reg   <= '0;
      off_reg    <= '0;
      size_known <= 1'b0;
      mode_reg   <= 2'd0;
      thr_reg    <= 8'h00;
      rx_v       <= 1'b0;
      rx_a       <= '0;
      pix_k      <= 2'd0;
      s1         <= '0;
      s2         <= '0;
      gray_reg   <= 8'h00;
    end else begin
      rx_v      <= ROM_valid;
      rx_a      <= ROM_addr;
      s1        <= rx_stage;
      s2        <= s1;
      RAM_valid <= s2.v;
      RAM_addr  <= s2.a;
      RAM_D     <= out_d;
      if (s2.v && s2.pix && s2.whole && s2.k == 2'd0)
        gray_reg <= gray_now;
      if (rx_stage.pix)
        pix_k <= (pix_k == K_LAST) ? 2'd0 : pix_k + 2'd1;
      if (rx_v) begin
        case (rx_ext)
          32'd2:  size_reg[7:0]   <= ROM_Q;
          32'd3:  size_reg[15:8]  <= ROM_Q;
          32'd4:  size_reg[23:16] <= ROM_Q;
          32'd5: begin
            size_reg[31:24] <= ROM_Q;
            size_known      <= 1'b1;
          end
          32'd10: off_reg[7:0]   <= ROM_Q;
          32'd11: off_reg[15:8]  <= ROM_Q;
          32'd12: off_reg[23:16] <= ROM_Q;
          32'd13: off_reg[31:24] <= ROM_Q;
          default: ;
        endcase
      end

      case (state)
        RUN, DRAIN: begin
          if (fault) begin
            state     <= ERR;
            ROM_valid <= 1'b0;
            rx_v      <= 1'b0;
            s1.v      <= 1'b0;
            s2.v      <= 1'b0;
            RAM_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
          end else if (state == RUN) begin
            if (rd_ext < limit) begin
              ROM_valid <= 1'b1;
              ROM_addr  <= rd_addr;
              rd_addr   <= rd_addr + 1'b1;
              if (rd_ext + 32'd1 >= limit)
                state <= DRAIN;
            end else begin
              ROM_valid <= 1'b0;
            end
          end else begin
            ROM_valid <= 1'b0;
            if (RAM_valid && 32'(RAM_addr) == limit - 32'd1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          ROM_valid <= 1'b0;
          if (in_valid) begin
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            mode_reg   <= mode;
            thr_reg    <= thr;
            rd_addr    <= '0;
            size_reg   <= '0;
            off_reg    <= '0;
            size_known <= 1'b0;
            pix_k      <= 2'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_stream_proc.sv
// Randomized self-checking bench for bmp_stream_proc: a BGR and a BGRA instance share one
// ROM image and are checked against a byte-level reference computed from the BMP rules.
module tb_bmp_stream_proc;

  localparam int AW     = 20;
  localparam int TB_MAX = 1000;
  localparam int MEM    = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [7:0]    thr = 8'h00;
  logic [7:0]    q3 = 8'h00, q4 = 8'h00;
  logic          rv3, wv3, busy3, done3, err3;
  logic          rv4, wv4, busy4, done4, err4;
  logic [AW-1:0] ra3, wa3, ra4, wa4;
  logic [7:0]    wd3, wd4;

  logic [7:0] rom  [MEM];
  logic [7:0] ram3 [MEM];
  logic [7:0] ram4 [MEM];
  int         tag3 [MEM];
  int         tag4 [MEM];
  int         run_id = 0;
  int         wr3 = 0, wr4 = 0;
  int         compared = 0, mismatched = 0;
  int         cur_size, cur_off;
  logic [1:0] cur_mode;
  logic [7:0] cur_thr;

  bmp_stream_proc #(.ADDR_WIDTH(AW), .MAX_SIZE(TB_MAX), .PIX_BYTES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .thr(thr), .ROM_Q(q3),
    .ROM_valid(rv3), .ROM_addr(ra3), .RAM_valid(wv3), .RAM_D(wd3), .RAM_addr(wa3),
    .busy(busy3), .done(done3), .err(err3));

  bmp_stream_proc #(.ADDR_WIDTH(AW), .MAX_SIZE(TB_MAX), .PIX_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .thr(thr), .ROM_Q(q4),
    .ROM_valid(rv4), .ROM_addr(ra4), .RAM_valid(wv4), .RAM_D(wd4), .RAM_addr(wa4),
    .busy(busy4), .done(done4), .err(err4));

  always #5 clk = ~clk;

  // Synchronous ROMs and write-logging RAMs; each RAM byte is tagged with the run that wrote it.
  always @(posedge clk) begin
    if (rv3) q3 <= rom[ra3[11:0]];
    if (rv4) q4 <= rom[ra4[11:0]];
    if (wv3) begin
      ram3[wa3[11:0]] <= wd3;
      tag3[wa3[11:0]] <= run_id;
      wr3 <= wr3 + 1;
    end
    if (wv4) begin
      ram4[wa4[11:0]] <= wd4;
      tag4[wa4[11:0]] <= run_id;
      wr4 <= wr4 + 1;
    end
  end

  function automatic logic [7:0] ref_byte(int pix, int a);
    int k, p, g;
    if (a < cur_off) return rom[a];
    k = (a - cur_off) % pix;
    p = a - k;
    if (p + pix > cur_size || k == 3 || cur_mode == 2'd0) return rom[a];
    if (cur_mode == 2'd1) return ~rom[a];
    g = (int'(rom[p]) + 2 * int'(rom[p+1]) + int'(rom[p+2])) / 4;
    if (cur_mode == 2'd2) return 8'(g);
    return (g >= int'(cur_thr)) ? 8'hFF : 8'h00;
  endfunction

  task automatic make_file(input int size, input int off);
    for (int i = 0; i < MEM; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h42;
    rom[1] = 8'h4D;
    for (int i = 0; i < 4; i++) begin
      rom[2+i]  = 8'(size >> (8*i));
      rom[10+i] = 8'(off >> (8*i));
    end
  endtask

  task automatic set_test_pixels();
    rom[54] = 8'h10; rom[55] = 8'h20; rom[56] = 8'h30;
    rom[57] = 8'hFF; rom[58] = 8'hFF; rom[59] = 8'hFF;
  endtask

  task automatic run_check(input string name, input int size, input int off,
                           input logic [1:0] md, input logic [7:0] th,
                           input int fault_byte, input int pulse_at);
    int  last_rd, last_wr, exp_done, exp_wr, base3, base4, bad, seen, bad3, bad4;
    logic exp_r, exp_w, is_fault;
    cur_size = size; cur_off = off; cur_mode = md; cur_thr = th;
    is_fault = (fault_byte >= 0);
    last_rd  = is_fault ? fault_byte + 2 : size;
    last_wr  = is_fault ? fault_byte + 2 : size + 4;
    exp_done = last_wr + 1;
    exp_wr   = is_fault ? ((fault_byte > 2) ? fault_byte - 2 : 0) : size;
    @(negedge clk);
    run_id++;
    in_valid = 1'b1; mode = md; thr = th;
    base3 = wr3; base4 = wr4;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0; bad = 0;
    for (int n = 1; n <= exp_done + 20 && seen == 0; n++) begin
      @(negedge clk);
      if (n == pulse_at) begin in_valid = 1'b1; mode = ~md; end
      else begin in_valid = 1'b0; mode = md; end
      exp_r = (n <= last_rd);
      exp_w = (n >= 5 && n <= last_wr);
      if (rv3 !== exp_r || (exp_r && ra3 !== AW'(n-1))) bad++;
      if (rv4 !== exp_r || (exp_r && ra4 !== AW'(n-1))) bad++;
      if (wv3 !== exp_w || (exp_w && wa3 !== AW'(n-5))) bad++;
      if (wv4 !== exp_w || (exp_w && wa4 !== AW'(n-5))) bad++;
      if (n < exp_done && {busy3, busy4, done3, done4} !== 4'b1100) bad++;
      if (n == exp_done && {busy3, busy4, done4} !== 3'b001) bad++;
      if (done3 === 1'b1) seen = n;
    end
    in_valid = 1'b0; mode = md;

    compared++;
    if (seen != exp_done) begin
      mismatched++;
      $display("[TB] FAIL %s done_cycle: got %0d expected %0d (0 = timeout)", name, seen, exp_done);
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL %s strobe_timing: got %0d bad cycles expected 0", name, bad);
    end
    compared++;
    if ({err3, err4, done4, busy3, busy4} !== {is_fault, is_fault, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL %s final_flags: got err=%b%b done4=%b busy=%b%b expected err=%b%b done4=1 busy=00",
               name, err3, err4, done4, busy3, busy4, is_fault, is_fault);
    end
    compared++;
    if (wr3 - base3 != exp_wr || wr4 - base4 != exp_wr) begin
      mismatched++;
      $display("[TB] FAIL %s write_count: got %0d/%0d expected %0d", name, wr3 - base3, wr4 - base4, exp_wr);
    end
    if (!is_fault) begin
      bad3 = 0; bad4 = 0;
      for (int a = 0; a < size; a++) begin
        if (tag3[a] != run_id || ram3[a] !== ref_byte(3, a)) bad3++;
        if (tag4[a] != run_id || ram4[a] !== ref_byte(4, a)) bad4++;
      end
      compared++;
      if (bad3 != 0) begin
        mismatched++;
        $display("[TB] FAIL %s image_bgr: got %0d wrong bytes expected 0", name, bad3);
      end
      compared++;
      if (bad4 != 0) begin
        mismatched++;
        $display("[TB] FAIL %s image_bgra: got %0d wrong bytes expected 0", name, bad4);
      end
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    compared++;
    if ({rv3, ra3, wv3, wd3, wa3, busy3, done3, err3, rv4, ra4, wv4, wd4, wa4, busy4, done4, err4} !== '0) begin
      mismatched++;
      $display("[TB] FAIL %s: got rv=%b%b wv=%b%b busy=%b%b done=%b%b err=%b%b expected all outputs 0",
               name, rv3, rv4, wv3, wv4, busy3, busy4, done3, done4, err3, err4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    check_outputs_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_copy();
    make_file(102, 54);
    run_check("copy", 102, 54, 2'd0, 8'h00, -1, 0);
  endtask

  task automatic test_invert();
    make_file(102, 54);
    rom[54] = 8'h10;
    rom[57] = 8'h80;
    run_check("invert", 102, 54, 2'd1, 8'h00, -1, 0);
    check_byte("invert_pixel", ram3[54], 8'hEF);
    check_byte("invert_alpha_kept", ram4[57], 8'h80);
    check_byte("invert_header", ram3[53], rom[53]);
  endtask

  task automatic test_gray();
    make_file(102, 54);
    set_test_pixels();
    run_check("gray", 102, 54, 2'd2, 8'h00, -1, 0);
    for (int i = 0; i < 3; i++) begin
      check_byte("gray_mid", ram3[54+i], 8'h20);
      check_byte("gray_white", ram3[57+i], 8'hFF);
    end
    check_byte("gray_bgra", ram4[56], 8'h20);
  endtask

  task automatic test_threshold();
    make_file(102, 54);
    set_test_pixels();
    run_check("thr_low", 102, 54, 2'd3, 8'h20, -1, 0);
    for (int i = 0; i < 3; i++) check_byte("thr_at_level", ram3[54+i], 8'hFF);
    run_check("thr_high", 102, 54, 2'd3, 8'h21, -1, 0);
    for (int i = 0; i < 3; i++) check_byte("thr_above_level", ram3[54+i], 8'h00);
  endtask

  task automatic test_errors();
    make_file(102, 54);
    rom[1] = 8'h41;
    run_check("bad_signature", 102, 54, 2'd0, 8'h00, 1, 0);
    make_file(TB_MAX + 1, 54);
    run_check("size_too_big", TB_MAX + 1, 54, 2'd0, 8'h00, 5, 0);
    make_file(53, 14);
    run_check("size_too_small", 53, 14, 2'd0, 8'h00, 5, 0);
    make_file(102, 102);
    run_check("off_eq_size", 102, 102, 2'd0, 8'h00, 13, 0);
    make_file(102, 13);
    run_check("off_too_small", 102, 13, 2'd1, 8'h00, 13, 0);
  endtask

  task automatic test_boundaries();
    make_file(TB_MAX, 54);
    run_check("size_max", TB_MAX, 54, 2'd3, 8'($urandom), -1, 0);
    make_file(60, 59);
    run_check("off_size_minus1", 60, 59, 2'd1, 8'h00, -1, 0);
  endtask

  task automatic test_control();
    int w3;
    make_file(150, 60);
    run_check("pulse_ignored", 150, 60, 2'd2, 8'h00, -1, 40);
    make_file(120, 54);
    @(negedge clk);
    in_valid = 1'b1; mode = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset_mid_transfer");
    w3 = wr3;
    repeat (3) @(negedge clk);
    compared++;
    if (wr3 != w3) begin
      mismatched++;
      $display("[TB] FAIL writes_after_reset: got %0d expected 0", wr3 - w3);
    end
    rst = 1'b0;
    run_check("restart_copy", 120, 54, 2'd0, 8'h00, -1, 0);
  endtask

  task automatic test_random();
    int size, off;
    for (int i = 0; i < 8; i++) begin
      size = $urandom_range(54, 400);
      off  = $urandom_range(14, size - 1);
      make_file(size, off);
      run_check("random", size, off, 2'($urandom), 8'($urandom), -1, 0);
    end
  endtask

  task automatic test_back_to_back();
    make_file(80, 54);
    run_check("b2b_first", 80, 54, 2'd2, 8'h00, -1, 0);
    run_check("b2b_second", 80, 54, 2'd1, 8'h00, -1, 0);
  endtask

  initial begin
    test_reset();
    test_copy();
    test_invert();
    test_gray();
    test_threshold();
    test_errors();
    test_boundaries();
    test_control();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
